control_fsm: RTL and testbench
==============================

Name: control_fsm

Overview:
- Multicycle control unit for the RV64 `processing` datapath.
- Consumes `instruction_out` and the ALU flags; produces every datapath control flag.
- Moore FSM: all outputs decode from registered state, except `PCWriteState` and `ALUOp`, which also depend on the current instruction fields and `alu_equal`.
- Supports ADD/SUB/AND/OR/XOR, ADDI, LUI, LD/LW/LH/LB, SD/SW/SH/SB, BEQ/BNE and JAL.
- Any other encoding traps.

Parameters:
ALU_ADD, 4'd0, ALU funct code for add
ALU_SUB, 4'd1, ALU funct code for subtract
ALU_AND, 4'd2, ALU funct code for and
ALU_OR, 4'd3, ALU funct code for or
ALU_XOR, 4'd4, ALU funct code for xor
ALU_PASSB, 4'd5, ALU funct code for result = b

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low (0 = reset)
instruction  input  32  instruction register contents
alu_zero, alu_equal, alu_greater, alu_less  input  1 each  ALU flags (only alu_equal used)
PCWrite, PCWriteCond, PCWriteState, PCSource  output  1 each  PC control
ALUSrcA  output  1  0 = PC, 1 = reg A
ALUSrcB  output  2  00 = B, 01 = 4, 10 = imm, 11 = imm<<2
ALUOp  output  4  ALU funct
LoadAOut, RegWrite, LoadRegA, LoadRegB  output  1 each  register loads
MemToReg  output  2  00 = ALUOut, 01 = load data, 10 = PC
DMemOp  output  1  data memory write
LoadMDR  output  1  memory data register load
LoadSplice, StoreSplice  output  2 each  access size
IMemRead, IRWrite  output  1 each  instruction fetch
halt  output  1  1 while in TRAP

Behaviour:
- Output defaults: every output is 0 unless a state below sets it. On `reset`=0 the state goes to RESET immediately and asynchronously, with all outputs 0 and `halt`=0.
- RESET: always moves to FETCH on the next clock.
- FETCH: `IMemRead`=1. Next state is FWAIT.
- FWAIT: `IMemRead`=1 to cover the 1-cycle synchronous read. Next state is IR.
- IR: `IRWrite`=1. Next state is DECODE.
- DECODE: `LoadRegA`=`LoadRegB`=1; ALUOut <= PC+imm (`ALUSrcA`=0, `ALUSrcB`=10, `ALU_ADD`, `LoadAOut`=1). Dispatch on opcode:
  - 0110011 -> EXR
  - 0010011 -> EXI
  - 0110111 -> EXLUI
  - 0000011 or 0100011 -> MADDR
  - 1100011 -> BR
  - 1101111 -> JAL1
  - anything else -> TRAP
- EXR:
  - ALUOut <= A op B (`ALUSrcA`=1, `ALUSrcB`=00, `LoadAOut`=1).
  - funct3/funct7 mapping: 000/0000000 = ADD, 000/0100000 = SUB, 111 = AND, 110 = OR, 100 = XOR.
  - Any other combination -> TRAP, else -> WB.
- EXI: funct3 000 only: ALUOut <= A+imm (`ALUSrcA`=1, `ALUSrcB`=10). Otherwise TRAP. Next state is WB.
- EXLUI: ALUOut <= imm (`ALU_PASSB`, `ALUSrcB`=10). Next state is WB.
- WB: `RegWrite`=1, `MemToReg`=00. In the same cycle PC <= PC+4 (`ALUSrcA`=0, `ALUSrcB`=01, `ALU_ADD`, `PCSource`=0, `PCWrite`=1). Next state is FETCH.
- MADDR: ALUOut <= A+imm. Load -> MRD, store -> MWR.
- Size mapping for LoadSplice/StoreSplice, driven in the state that uses it: funct3 011 -> 00, 010 -> 01, 001 -> 10, 000 -> 11. Any other funct3 in DECODE for a load/store -> TRAP.
- MRD: wait one cycle. Next state is MLD.
- MLD: `LoadMDR`=1. Next state is LWB.
- LWB: `RegWrite`=1, `MemToReg`=01, LoadSplice driven; PC+4 as in WB. Next state is FETCH.
- MWR: `DMemOp`=1, StoreSplice driven; PC+4 as in WB. Exactly one write cycle. Next state is FETCH.
- BR:
  - Compare A-B (`ALUSrcA`=1, `ALUSrcB`=00, `ALU_SUB`); `PCWriteCond`=1, `PCSource`=1 (target held in ALUOut).
  - taken = (funct3==000) & `alu_equal` | (funct3==001) & !`alu_equal`.
  - Taken -> FETCH, not taken -> NEXT. Any other funct3 -> TRAP, with no PC write.
- NEXT: PC+4 as in WB, no register write. Next state is FETCH.
- JAL1: PC <= PC+4 via the ALU, `PCSource`=0, `PCWrite`=1. ALUOut keeps the target. Next state is JAL2.
- JAL2: `RegWrite`=1, `MemToReg`=10 (rd = current PC = old PC+4); `PCWrite`=1, `PCSource`=1 (PC <= target). Both update on the same edge. Next state is FETCH.
- TRAP: `halt`=1, all other outputs 0. Held until reset.
- `PCWriteState` = `PCWrite` | (`PCWriteCond` & taken), combinational; this is the only PC load the datapath uses.
- Cycle counts per instruction:
  - R-type, I-type and LUI: 6
  - Load: 8
  - Store: 6
  - Branch taken: 5; not taken: 6
  - JAL: 6
- Reset mid-instruction: the instruction is abandoned and any pending write is suppressed. Outputs fall to 0 asynchronously.

Test Plan:
- Hold reset=0 for 3 cycles, release -> all outputs 0 while held; RESET, then FETCH with `IMemRead`=1 one cycle after release.
- instruction=0x00B50533 (add x10,x10,x11) -> EXR `ALUOp`=ALU_ADD; WB `RegWrite`=1 `MemToReg`=00 `PCWriteState`=1; back at FETCH after 6 cycles.
- 0x00853503 (ld x10,8(x10)) -> MLD `LoadMDR`=1; LWB `MemToReg`=01 `LoadSplice`=00; 8 cycles total. 0x00A52023 (sw) -> MWR `DMemOp`=1 for exactly 1 cycle with `StoreSplice`=01.
- 0x00B50463 (beq) with `alu_equal`=1 -> `PCWriteState`=1 `PCSource`=1 in BR. With `alu_equal`=0 -> `PCWriteState`=0 in BR, then NEXT with `PCSource`=0 `PCWrite`=1.
- 0x008000EF (jal x1,8) -> JAL1 `PCWrite`=1 `PCSource`=0; JAL2 `RegWrite`=1 `MemToReg`=10 `PCSource`=1.
- Opcode 0x7F, or R-type with funct7=0x01 -> `halt`=1, all other outputs 0, held for 10 cycles. Drive reset=0 mid-LWB -> `RegWrite` falls to 0 asynchronously.

Source files
------------

// File: rtl/control_fsm.sv
// Multicycle control unit for the RV64 processing datapath.
// The state register and the Moore control word are registered together.
// Only ALUOp and PCWriteState are decoded combinationally, because they
// also depend on the instruction fields and on alu_equal.
`timescale 1ns/1ps
module control_fsm #(
  parameter logic [3:0] ALU_ADD   = 4'd0,
  parameter logic [3:0] ALU_SUB   = 4'd1,
  parameter logic [3:0] ALU_AND   = 4'd2,
  parameter logic [3:0] ALU_OR    = 4'd3,
  parameter logic [3:0] ALU_XOR   = 4'd4,
  parameter logic [3:0] ALU_PASSB = 4'd5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        alu_zero,
  input  logic        alu_equal,
  input  logic        alu_greater,
  input  logic        alu_less,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCWriteState,
  output logic        PCSource,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUOp,
  output logic        LoadAOut,
  output logic        RegWrite,
  output logic        LoadRegA,
  output logic        LoadRegB,
  output logic [1:0]  MemToReg,
  output logic        DMemOp,
  output logic        LoadMDR,
  output logic [1:0]  LoadSplice,
  output logic [1:0]  StoreSplice,
  output logic        IMemRead,
  output logic        IRWrite,
  output logic        halt
);

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRAN  = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [4:0] {
    S_RESET, S_FETCH, S_FWAIT, S_IR, S_DECODE,
    S_EXR, S_EXI, S_EXLUI, S_WB,
    S_MADDR, S_MRD, S_MLD, S_LWB, S_MWR,
    S_BR, S_NEXT, S_JAL1, S_JAL2, S_TRAP
  } state_e;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       pcSource;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       loadAOut;
    logic       regWrite;
    logic       loadRegA;
    logic       loadRegB;
    logic [1:0] memToReg;
    logic       dMemOp;
    logic       loadMdr;
    logic [1:0] loadSplice;
    logic [1:0] storeSplice;
    logic       iMemRead;
    logic       irWrite;
    logic       halt;
  } ctrl_t;

  state_e     state_q, state_d;
  ctrl_t      ctrl_q;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] rOp;
  logic       rLegal;
  logic       branchTaken;
  logic       unusedBits;

  assign opcode     = instruction[6:0];
  assign funct3     = instruction[14:12];
  assign funct7     = instruction[31:25];
  assign unusedBits = ^{alu_zero, alu_greater, alu_less,
                        instruction[11:7], instruction[24:15]};

  // Control word held by each state; access size is the inverted low funct3 bits
  // (ld/sd 011 -> 00, w 010 -> 01, h 001 -> 10, b 000 -> 11).
  function automatic ctrl_t decodeCtrl(input state_e s, input logic [2:0] f3);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH, S_FWAIT: c.iMemRead = 1'b1;
      S_IR:             c.irWrite = 1'b1;
      S_DECODE: begin
        c.loadRegA = 1'b1;
        c.loadRegB = 1'b1;
        c.aluSrcB  = 2'b10;
        c.loadAOut = 1'b1;
      end
      S_EXR: begin
        c.aluSrcA  = 1'b1;
        c.loadAOut = 1'b1;
      end
      S_EXI, S_MADDR: begin
        c.aluSrcA  = 1'b1;
        c.aluSrcB  = 2'b10;
        c.loadAOut = 1'b1;
      end
      S_EXLUI: begin
        c.aluSrcB  = 2'b10;
        c.loadAOut = 1'b1;
      end
      S_WB: begin
        c.pcWrite  = 1'b1;
        c.aluSrcB  = 2'b01;
        c.regWrite = 1'b1;
      end
      S_MLD: c.loadMdr = 1'b1;
      S_LWB: begin
        c.pcWrite    = 1'b1;
        c.aluSrcB    = 2'b01;
        c.regWrite   = 1'b1;
        c.memToReg   = 2'b01;
        c.loadSplice = ~f3[1:0];
      end
      S_MWR: begin
        c.pcWrite     = 1'b1;
        c.aluSrcB     = 2'b01;
        c.dMemOp      = 1'b1;
        c.storeSplice = ~f3[1:0];
      end
      S_BR: begin
        c.aluSrcA     = 1'b1;
        c.pcWriteCond = 1'b1;
        c.pcSource    = 1'b1;
      end
      S_NEXT, S_JAL1: begin
        c.pcWrite = 1'b1;
        c.aluSrcB = 2'b01;
      end
      S_JAL2: begin
        c.pcWrite  = 1'b1;
        c.pcSource = 1'b1;
        c.regWrite = 1'b1;
        c.memToReg = 2'b10;
      end
      S_TRAP:  c.halt = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  // Map R-type funct3/funct7 onto an ALU operation and flag illegal combinations.
  always_comb begin
    rOp    = ALU_ADD;
    rLegal = 1'b1;
    case (funct3)
      3'b000: begin
        if (funct7 == 7'b0100000)      rOp = ALU_SUB;
        else if (funct7 != 7'b0000000) rLegal = 1'b0;
      end
      3'b111:  begin rOp = ALU_AND; rLegal = (funct7 == 7'b0000000); end
      3'b110:  begin rOp = ALU_OR;  rLegal = (funct7 == 7'b0000000); end
      3'b100:  begin rOp = ALU_XOR; rLegal = (funct7 == 7'b0000000); end
      default: rLegal = 1'b0;
    endcase
  end

  assign branchTaken = ((funct3 == 3'b000) &  alu_equal) |
                       ((funct3 == 3'b001) & ~alu_equal);

  // Next-state sequencing, including opcode dispatch and illegal-encoding traps.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = S_FWAIT;
      S_FWAIT:  state_d = S_IR;
      S_IR:     state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:          state_d = S_EXR;
          OP_ITYPE:          state_d = S_EXI;
          OP_LUI:            state_d = S_EXLUI;
          OP_LOAD, OP_STORE: state_d = funct3[2] ? S_TRAP : S_MADDR;
          OP_BRAN:           state_d = S_BR;
          OP_JAL:            state_d = S_JAL1;
          default:           state_d = S_TRAP;
        endcase
      end
      S_EXR:    state_d = rLegal ? S_WB : S_TRAP;
      S_EXI:    state_d = (funct3 == 3'b000) ? S_WB : S_TRAP;
      S_EXLUI:  state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_MADDR:  state_d = (opcode == OP_LOAD) ? S_MRD : S_MWR;
      S_MRD:    state_d = S_MLD;
      S_MLD:    state_d = S_LWB;
      S_LWB:    state_d = S_FETCH;
      S_MWR:    state_d = S_FETCH;
      S_BR: begin
        if (funct3[2:1] != 2'b00) state_d = S_TRAP;
        else if (branchTaken)     state_d = S_FETCH;
        else                      state_d = S_NEXT;
      end
      S_NEXT:   state_d = S_FETCH;
      S_JAL1:   state_d = S_JAL2;
      S_JAL2:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_RESET;
    endcase
  end

  // ALU function: operation-specific in EXR/EXLUI/BR, add everywhere else.
  always_comb begin
    ALUOp = ALU_ADD;
    case (state_q)
      S_EXR:   ALUOp = rOp;
      S_EXLUI: ALUOp = ALU_PASSB;
      S_BR:    ALUOp = ALU_SUB;
      default: ;
    endcase
  end

  // State and control word registered together; reset abandons any pending write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decodeCtrl(state_d, funct3);
    end
  end

  assign PCWrite      = ctrl_q.pcWrite;
  assign PCWriteCond  = ctrl_q.pcWriteCond;
  assign PCWriteState = ctrl_q.pcWrite | (ctrl_q.pcWriteCond & branchTaken);
  assign PCSource     = ctrl_q.pcSource;
  assign ALUSrcA      = ctrl_q.aluSrcA;
  assign ALUSrcB      = ctrl_q.aluSrcB;
  assign LoadAOut     = ctrl_q.loadAOut;
  assign RegWrite     = ctrl_q.regWrite;
  assign LoadRegA     = ctrl_q.loadRegA;
  assign LoadRegB     = ctrl_q.loadRegB;
  assign MemToReg     = ctrl_q.memToReg;
  assign DMemOp       = ctrl_q.dMemOp;
  assign LoadMDR      = ctrl_q.loadMdr;
  assign LoadSplice   = ctrl_q.loadSplice;
  assign StoreSplice  = ctrl_q.storeSplice;
  assign IMemRead     = ctrl_q.iMemRead;
  assign IRWrite      = ctrl_q.irWrite;
  assign halt         = ctrl_q.halt;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: walks each instruction class state by state
// and compares the whole control word against hand-built expected values.
`timescale 1ns/1ps
module tb_control_fsm;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic        alu_zero, alu_equal, alu_greater, alu_less;
  logic        PCWrite, PCWriteCond, PCWriteState, PCSource, ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [3:0]  ALUOp;
  logic        LoadAOut, RegWrite, LoadRegA, LoadRegB;
  logic [1:0]  MemToReg;
  logic        DMemOp, LoadMDR;
  logic [1:0]  LoadSplice, StoreSplice;
  logic        IMemRead, IRWrite, halt;
  logic [25:0] allOut;
  int          checks;
  int          errors;

  // Field positions inside allOut
  localparam logic [25:0] PCW      = 26'd1 << 25;
  localparam logic [25:0] PCWC     = 26'd1 << 24;
  localparam logic [25:0] PCWS     = 26'd1 << 23;
  localparam logic [25:0] PCSRC    = 26'd1 << 22;
  localparam logic [25:0] SRCA     = 26'd1 << 21;
  localparam logic [25:0] SRCB_4   = 26'd1 << 19;
  localparam logic [25:0] SRCB_IMM = 26'd2 << 19;
  localparam logic [25:0] OP_SUB   = 26'd1 << 15;
  localparam logic [25:0] OP_XOR   = 26'd4 << 15;
  localparam logic [25:0] OP_PASSB = 26'd5 << 15;
  localparam logic [25:0] LAOUT    = 26'd1 << 14;
  localparam logic [25:0] RW       = 26'd1 << 13;
  localparam logic [25:0] LRA      = 26'd1 << 12;
  localparam logic [25:0] LRB      = 26'd1 << 11;
  localparam logic [25:0] M2R_MEM  = 26'd1 << 9;
  localparam logic [25:0] M2R_PC   = 26'd2 << 9;
  localparam logic [25:0] DMEM     = 26'd1 << 8;
  localparam logic [25:0] LMDR     = 26'd1 << 7;
  localparam logic [25:0] LS_B     = 26'd3 << 5;
  localparam logic [25:0] SS_W     = 26'd1 << 3;
  localparam logic [25:0] IMEM     = 26'd1 << 2;
  localparam logic [25:0] IRW      = 26'd1 << 1;
  localparam logic [25:0] HALT     = 26'd1;

  localparam logic [25:0] WB_VEC  = PCW | PCWS | SRCB_4 | RW;
  localparam logic [25:0] LWB_VEC = PCW | PCWS | SRCB_4 | RW | M2R_MEM;
  localparam logic [25:0] MA_VEC  = SRCA | SRCB_IMM | LAOUT;
  localparam logic [25:0] BR_VEC  = PCWC | PCSRC | SRCA | OP_SUB;

  control_fsm dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .alu_zero(alu_zero), .alu_equal(alu_equal),
    .alu_greater(alu_greater), .alu_less(alu_less),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteState(PCWriteState),
    .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .LoadAOut(LoadAOut), .RegWrite(RegWrite), .LoadRegA(LoadRegA),
    .LoadRegB(LoadRegB), .MemToReg(MemToReg), .DMemOp(DMemOp),
    .LoadMDR(LoadMDR), .LoadSplice(LoadSplice), .StoreSplice(StoreSplice),
    .IMemRead(IMemRead), .IRWrite(IRWrite), .halt(halt)
  );

  assign allOut = {PCWrite, PCWriteCond, PCWriteState, PCSource, ALUSrcA,
                   ALUSrcB, ALUOp, LoadAOut, RegWrite, LoadRegA, LoadRegB,
                   MemToReg, DMemOp, LoadMDR, LoadSplice, StoreSplice,
                   IMemRead, IRWrite, halt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [25:0] expected);
    checks++;
    assert (allOut === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, allOut, expected);
      end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic eq);
    instruction = instr;
    alu_equal   = eq;
  endtask

  task automatic fetchToExecute(input string tag);
    checkOutput({tag, ".fetch"}, IMEM);
    @(negedge clk);
    checkOutput({tag, ".fwait"}, IMEM);
    @(negedge clk);
    checkOutput({tag, ".ir"}, IRW);
    @(negedge clk);
    checkOutput({tag, ".decode"}, LRA | LRB | SRCB_IMM | LAOUT);
    @(negedge clk);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    instruction = 32'h00B50533;
    alu_zero    = 1'b0;
    alu_equal   = 1'b0;
    alu_greater = 1'b0;
    alu_less    = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset.held", '0);
    reset = 1'b1;
    checkOutput("reset.release", '0);
    @(negedge clk);

    applyStimulus(32'h00B50533, 1'b0);
    fetchToExecute("add");
    checkOutput("add.exr", SRCA | LAOUT);
    @(negedge clk);
    checkOutput("add.wb", WB_VEC);
    @(negedge clk);

    applyStimulus(32'h40B50533, 1'b0);
    fetchToExecute("sub");
    checkOutput("sub.exr", SRCA | LAOUT | OP_SUB);
    repeat (2) @(negedge clk);

    applyStimulus(32'h00B54533, 1'b0);
    fetchToExecute("xor");
    checkOutput("xor.exr", SRCA | LAOUT | OP_XOR);
    repeat (2) @(negedge clk);

    applyStimulus(32'h00150513, 1'b0);
    fetchToExecute("addi");
    checkOutput("addi.exi", SRCA | SRCB_IMM | LAOUT);
    @(negedge clk);
    checkOutput("addi.wb", WB_VEC);
    @(negedge clk);

    applyStimulus(32'h000015B7, 1'b0);
    fetchToExecute("lui");
    checkOutput("lui.exlui", SRCB_IMM | LAOUT | OP_PASSB);
    repeat (2) @(negedge clk);

    applyStimulus(32'h00853503, 1'b0);
    fetchToExecute("ld");
    checkOutput("ld.maddr", MA_VEC);
    @(negedge clk);
    checkOutput("ld.mrd", '0);
    @(negedge clk);
    checkOutput("ld.mld", LMDR);
    @(negedge clk);
    checkOutput("ld.lwb", LWB_VEC);
    @(negedge clk);

    applyStimulus(32'h00850503, 1'b0);
    fetchToExecute("lb");
    repeat (3) @(negedge clk);
    checkOutput("lb.lwb", LWB_VEC | LS_B);
    @(negedge clk);

    applyStimulus(32'h00A52023, 1'b0);
    fetchToExecute("sw");
    checkOutput("sw.maddr", MA_VEC);
    @(negedge clk);
    checkOutput("sw.mwr", PCW | PCWS | SRCB_4 | DMEM | SS_W);
    @(negedge clk);

    applyStimulus(32'h00B50463, 1'b1);
    fetchToExecute("beqT");
    checkOutput("beqT.br", BR_VEC | PCWS);
    @(negedge clk);

    applyStimulus(32'h00B50463, 1'b0);
    fetchToExecute("beqN");
    checkOutput("beqN.br", BR_VEC);
    @(negedge clk);
    checkOutput("beqN.next", PCW | PCWS | SRCB_4);
    @(negedge clk);

    applyStimulus(32'h00B51463, 1'b0);
    fetchToExecute("bneT");
    checkOutput("bneT.br", BR_VEC | PCWS);
    @(negedge clk);

    applyStimulus(32'h008000EF, 1'b0);
    fetchToExecute("jal");
    checkOutput("jal.jal1", PCW | PCWS | SRCB_4);
    @(negedge clk);
    checkOutput("jal.jal2", PCW | PCWS | PCSRC | RW | M2R_PC);
    @(negedge clk);

    applyStimulus(32'h0000007F, 1'b0);
    fetchToExecute("illop");
    checkOutput("illop.trap", HALT);
    repeat (10) @(negedge clk);
    checkOutput("illop.hold", HALT);
    reset = 1'b0;
    #1;
    checkOutput("illop.reset", '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    applyStimulus(32'h02B50533, 1'b0);
    fetchToExecute("badr");
    checkOutput("badr.exr", SRCA | LAOUT);
    @(negedge clk);
    checkOutput("badr.trap", HALT);
    repeat (10) @(negedge clk);
    checkOutput("badr.hold", HALT);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    applyStimulus(32'h00853503, 1'b0);
    fetchToExecute("ldrst");
    repeat (3) @(negedge clk);
    checkOutput("ldrst.lwb", LWB_VEC);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("ldrst.abort", '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("ldrst.refetch", IMEM);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
